// File: rtl/hicore_issue_queue_pkg.sv
// Shared HiCore issue-stage constants: FU channel count and indices, queue depth and payload width.
package hicore_issue_queue_pkg;

    localparam int HICORE_ISSUE_FU_NUM  = 5;
    localparam int HICORE_ISSUEQ_DEPTH  = 4;

    // Payload is the ALU-side operand bundle plus the decode-side side-band (rd, rob_ptr, pc/excp/irq).
    localparam int HICORE_ISSUE2ALU_INFO_W = 64;
    localparam int HICORE_DE2ISSUE_SIDE_W  = 32;
    localparam int HICORE_ISSUE_INFO_W     = HICORE_ISSUE2ALU_INFO_W + HICORE_DE2ISSUE_SIDE_W;

    localparam int HICORE_FU_BJP = 0;
    localparam int HICORE_FU_ALU = 1;
    localparam int HICORE_FU_AGU = 2;
    localparam int HICORE_FU_CSR = 3;
    localparam int HICORE_FU_NOP = 4;

endpackage

// File: rtl/hicore_issue_fifo_mem.sv
// DEPTH-entry register array with read/write pointers and occupancy; flush empties it on the next edge.
module hicore_issue_fifo_mem #(
    parameter int ENTRY_W = 102,
    parameter int DEPTH   = 4,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [PTR_W:0]     count,
    output logic               empty,
    output logic               full
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/hicore_issue_queue.sv
// In-order decode-to-issue queue steering the head entry to one of NUM_FU channels.
// Optional same-cycle empty-queue bypass enabled by defining HICORE_ISSUE_BYPASS_EN.
module hicore_issue_queue
    import hicore_issue_queue_pkg::*;
#(
    parameter int INFO_W = HICORE_ISSUE_INFO_W,
    parameter int NUM_FU = HICORE_ISSUE_FU_NUM,
    parameter int DEPTH  = HICORE_ISSUEQ_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_de2issue_valid,
    output logic              i_de2issue_ready,
    input  logic              i_de2issue_cancel,
    input  logic [NUM_FU-1:0] i_de2issue_sel,
    input  logic [INFO_W-1:0] i_de2issue_info,
    output logic [NUM_FU-1:0] o_fu_valid,
    input  logic [NUM_FU-1:0] i_fu_ready,
    output logic [INFO_W-1:0] o_fu_info,
    output logic              o_fu_cancel,
    output logic [PTR_W:0]    o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_sel_err
);

    localparam int ENTRY_W = INFO_W + NUM_FU + 1;
    localparam int CNT_W   = $clog2(NUM_FU + 1);

    logic [CNT_W-1:0]   sel_ones;
    logic               sel_legal;
    logic [ENTRY_W-1:0] head_entry;
    logic               head_err;
    logic [NUM_FU-1:0]  head_sel;
    logic [INFO_W-1:0]  head_info;
    logic               q_issue;
    logic [NUM_FU-1:0]  q_fu_valid;
    logic               pop;
    logic               push;
    logic               bypass_take;

    always_comb begin
        sel_ones = '0;
        for (int i = 0; i < NUM_FU; i++) sel_ones = sel_ones + CNT_W'(i_de2issue_sel[i]);
        sel_legal = (sel_ones == CNT_W'(1));
    end

    assign {head_err, head_sel, head_info} = head_entry;

    // An err entry never reaches an FU; it is simply drained.
    assign q_issue    = !o_empty && !i_de2issue_cancel && !head_err;
    assign q_fu_valid = head_sel & {NUM_FU{q_issue}};
    assign pop        = !o_empty && !i_de2issue_cancel && (head_err || |(q_fu_valid & i_fu_ready));

`ifdef HICORE_ISSUE_BYPASS_EN
    logic bypass_act;
    assign bypass_act  = o_empty && sel_legal && !i_de2issue_cancel;
    assign o_fu_valid  = bypass_act ? (i_de2issue_sel & {NUM_FU{i_de2issue_valid}}) : q_fu_valid;
    assign o_fu_info   = bypass_act ? i_de2issue_info : head_info;
    assign bypass_take = bypass_act && i_de2issue_valid && |(i_de2issue_sel & i_fu_ready);
`else
    assign o_fu_valid  = q_fu_valid;
    assign o_fu_info   = head_info;
    assign bypass_take = 1'b0;
`endif

    assign i_de2issue_ready = !o_full && !i_de2issue_cancel;
    assign push             = i_de2issue_valid && i_de2issue_ready && !bypass_take;

    hicore_issue_fifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (i_de2issue_cancel),
        .wr_en   (push),
        .wr_data ({!sel_legal, i_de2issue_sel, i_de2issue_info}),
        .rd_en   (pop),
        .rd_data (head_entry),
        .count   (o_count),
        .empty   (o_empty),
        .full    (o_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fu_cancel <= 1'b0;
            o_sel_err   <= 1'b0;
        end else begin
            o_fu_cancel <= i_de2issue_cancel;
            if (pop && head_err) o_sel_err <= 1'b1;
        end
    end

endmodule
